// File: rtl/ika_timinggen_param.sv
// IKA timing generator: phiM cen -> phi1 divider, MRST sync, slot counter, SH1/SH2, programmable slot decoders.
// Define IKA_TIMINGGEN_SYNC_EN to add i_SYNC_n, which reloads the slot counter to 0.
module ika_timinggen_param #(
  parameter int SLOT_W   = 5,
  parameter int PHI_DIV  = 2,
  parameter int RST_SYNC = 2,
  parameter int SH_DLY   = 5,
  parameter int NUM_DEC  = 4
) (
  input  logic                      i_EMUCLK,
  input  logic                      i_IC_n,
  input  logic                      i_phiM_PCEN_n,
  output logic                      o_MRST_n,
  output logic                      o_phi1,
  output logic                      o_phi1_PCEN_n,
  output logic                      o_phi1_NCEN_n,
  input  logic [NUM_DEC*SLOT_W-1:0] i_DEC_SLOT,
  input  logic [NUM_DEC*SLOT_W-1:0] i_DEC_MASK,
  output logic [NUM_DEC-1:0]        o_DEC,
  output logic [SLOT_W-1:0]         o_SLOT,
  output logic                      o_FRAME,
`ifdef IKA_TIMINGGEN_SYNC_EN
  input  logic                      i_SYNC_n,
`endif
  output logic                      o_SH1,
  output logic                      o_SH2
);

  localparam int HALF  = PHI_DIV / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  logic [DIV_W-1:0]    r_div;
  logic                r_phi1;
  logic [RST_SYNC-1:0] r_sync;
  logic                r_mrst_n;
  logic [SLOT_W-1:0]   r_slot;
  logic [NUM_DEC-1:0]  r_dec;
  logic                r_frame;
  logic [SH_DLY-1:0]   r_sh1;
  logic [SH_DLY-1:0]   r_sh2;

  logic                w_cen;
  logic                w_tog;
  logic                w_pcen;
  logic                w_ncen;
  logic [SLOT_W-1:0]   w_slot_nxt;
  logic [NUM_DEC-1:0]  w_dec_hit;
  logic                w_sh1_raw;
  logic                w_sh2_raw;

  // cen pulses are suppressed while i_IC_n is low
  assign w_cen  = ~i_phiM_PCEN_n;
  assign w_tog  = i_IC_n & w_cen & (r_div == DIV_LAST);
  assign w_pcen = w_tog & ~r_phi1;
  assign w_ncen = w_tog & r_phi1;

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      r_div  <= '0;
      r_phi1 <= 1'b1;
      r_sync <= '0;
    end else if (w_cen) begin
      r_sync <= {r_sync[RST_SYNC-2:0], i_IC_n};
      if (r_div == DIV_LAST) begin
        r_div  <= '0;
        r_phi1 <= ~r_phi1;
      end else begin
        r_div  <= r_div + 1'b1;
      end
    end
  end

  // MRST has priority over the external frame sync
  always_comb begin
    w_slot_nxt = r_slot + 1'b1;
    if (!r_mrst_n)
      w_slot_nxt = '0;
`ifdef IKA_TIMINGGEN_SYNC_EN
    else if (!i_SYNC_n)
      w_slot_nxt = '0;
`endif
  end

  always_comb begin
    w_dec_hit = '0;
    for (int k = 0; k < NUM_DEC; k++)
      w_dec_hit[k] = ((r_slot ^ i_DEC_SLOT[k*SLOT_W +: SLOT_W])
                     & ~i_DEC_MASK[k*SLOT_W +: SLOT_W]) == '0;
  end

  assign w_sh1_raw = r_slot[SLOT_W-1:SLOT_W-2] == 2'b11;
  assign w_sh2_raw = r_slot[SLOT_W-1:SLOT_W-2] == 2'b01;

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      r_mrst_n <= 1'b0;
      r_slot   <= '0;
      r_dec    <= '0;
      r_frame  <= 1'b0;
      r_sh1    <= '0;
      r_sh2    <= '0;
    end else if (w_ncen) begin
      r_mrst_n <= r_sync[RST_SYNC-1];
      r_slot   <= w_slot_nxt;
      r_dec    <= w_dec_hit;
      r_frame  <= &r_slot;
      r_sh1    <= (r_sh1 << 1) | SH_DLY'(w_sh1_raw);
      r_sh2    <= (r_sh2 << 1) | SH_DLY'(w_sh2_raw);
    end
  end

  assign o_MRST_n      = r_mrst_n;
  assign o_phi1        = r_phi1;
  assign o_phi1_PCEN_n = ~w_pcen;
  assign o_phi1_NCEN_n = ~w_ncen;
  assign o_SLOT        = r_slot;
  assign o_DEC         = r_dec;
  assign o_FRAME       = r_frame;
  assign o_SH1         = r_sh1[SH_DLY-1] & r_mrst_n;
  assign o_SH2         = r_sh2[SH_DLY-1] & r_mrst_n;

endmodule

// File: tb/tb_ika_timinggen_param.sv
// Directed bench for ika_timinggen_param at default parameters.
// phiM cen every 4th EMUCLK; SYNC scenario runs when IKA_TIMINGGEN_SYNC_EN is defined.
module tb_ika_timinggen_param;
  localparam int SW = 5;
  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          ic_n = 1'b0;
  logic          pcen_n = 1'b1;
  logic [ND*SW-1:0] dslot;
  logic [ND*SW-1:0] dmask;
  logic          mrst_n, phi1, p_n, n_n, frame, sh1, sh2;
  logic [ND-1:0] dec;
  logic [SW-1:0] slot;
`ifdef IKA_TIMINGGEN_SYNC_EN
  logic          sync_n = 1'b1;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cen_cnt = 0;

  ika_timinggen_param dut (
    .i_EMUCLK      (clk),
    .i_IC_n        (ic_n),
    .i_phiM_PCEN_n (pcen_n),
    .o_MRST_n      (mrst_n),
    .o_phi1        (phi1),
    .o_phi1_PCEN_n (p_n),
    .o_phi1_NCEN_n (n_n),
    .i_DEC_SLOT    (dslot),
    .i_DEC_MASK    (dmask),
    .o_DEC         (dec),
    .o_SLOT        (slot),
    .o_FRAME       (frame),
`ifdef IKA_TIMINGGEN_SYNC_EN
    .i_SYNC_n      (sync_n),
`endif
    .o_SH1         (sh1),
    .o_SH2         (sh2)
  );

  // cen is low for one EMUCLK every 4th cycle
  initial forever begin
    @(posedge clk);
    #1;
    cen_cnt = (cen_cnt == 3) ? 0 : cen_cnt + 1;
    pcen_n  = (cen_cnt != 3);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // which: 0 = PCEN, 1 = NCEN; n = negedges waited
  task automatic wait_low(input int which, output int n);
    bit hit;
    hit = 0;
    n = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      n++;
      hit = (which == 0) ? !p_n : !n_n;
    end
    if (!hit) chk("cen_timeout", 0, 1);
  endtask

  task automatic next_slot();
    int n;
    wait_low(1, n);
    @(negedge clk);
  endtask

  task automatic startup();
    int n;
    for (int i = 0; i < 8 && cen_cnt != 0; i++) @(negedge clk);
    ic_n = 1'b1;
    wait_low(1, n);
    chk("first_ncen_dly", n, 3);
    chk("phi1_pre_ncen", phi1, 1);
    @(negedge clk);
    chk("phi1_low", phi1, 0);
    chk("mrst_still_low", mrst_n, 0);
    chk("slot_hold0", slot, 0);
    wait_low(0, n);
    chk("pcen_dly", n, 3);
    @(negedge clk);
    chk("phi1_high", phi1, 1);
    wait_low(1, n);
    chk("ncen_dly", n, 3);
    @(negedge clk);
    chk("mrst_rise", mrst_n, 1);
    chk("slot_at_mrst", slot, 0);
    next_slot();
    chk("slot_first_inc", slot, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mrst"}, mrst_n, 0);
    chk({tag, "_phi1"}, phi1, 1);
    chk({tag, "_slot"}, slot, 0);
    chk({tag, "_dec"}, dec, 0);
    chk({tag, "_frame"}, frame, 0);
    chk({tag, "_sh1"}, sh1, 0);
    chk({tag, "_sh2"}, sh2, 0);
    chk({tag, "_pcen"}, p_n, 1);
    chk({tag, "_ncen"}, n_n, 1);
  endtask

  initial begin
    int s;
    int e;
    dslot = {5'd31, 5'd0, 5'd5, 5'd12};
    dmask = {5'd0, 5'h1f, 5'b10000, 5'd0};

    repeat (10) @(negedge clk);
    chk_reset("rst");
    startup();

    repeat (31) next_slot();
    chk("wrap_to0", slot, 0);
    for (int i = 0; i < 64; i++) begin
      s = i % 32;
      e = int'(s == 13) | (int'(s == 6 || s == 22) << 1) | 4 | (int'(s == 0) << 3);
      chk("run_slot", slot, s);
      chk("run_frame", frame, int'(s == 0));
      chk("run_dec", dec, e);
      chk("run_sh1", sh1, int'(s >= 29 || s <= 4));
      chk("run_sh2", sh2, int'(s >= 13 && s <= 20));
      next_slot();
    end

    repeat (17) next_slot();
    chk("mid_slot17", slot, 17);
    ic_n = 1'b0;
    @(negedge clk);
    chk_reset("mid");
    repeat (10) @(negedge clk);
    startup();
    repeat (4) next_slot();
    chk("restart_slot5", slot, 5);

`ifdef IKA_TIMINGGEN_SYNC_EN
    for (int i = 0; i < 40 && slot != 9; i++) next_slot();
    chk("sync_at9", slot, 9);
    sync_n = 1'b0;
    next_slot();
    sync_n = 1'b1;
    chk("sync_slot0", slot, 0);
    chk("sync_noframe", frame, 0);
    repeat (31) next_slot();
    chk("sync_slot31", slot, 31);
    chk("sync_frame_lo", frame, 0);
    next_slot();
    chk("sync_wrap", slot, 0);
    chk("sync_frame_hi", frame, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
